// File: rtl/v_pkg.sv
// Opcode, funct3 category and addressing-mode constants for RVV encoding,
// plus the request class and encoder state types shared by the encoder files.
package v_pkg;

   localparam logic [6:0] OPC_LTYPE = 7'b0000111;
   localparam logic [6:0] OPC_STYPE = 7'b0100111;
   localparam logic [6:0] OPC_RTYPE = 7'b1010111;
   localparam logic [2:0] OP_SET    = 3'b111;

   localparam logic [2:0] OPI_VV = 3'b000;
   localparam logic [2:0] OPM_VV = 3'b010;
   localparam logic [2:0] OPI_VI = 3'b011;
   localparam logic [2:0] OPI_VX = 3'b100;
   localparam logic [2:0] OPM_VX = 3'b110;

   localparam logic [1:0] MOP_UNIT      = 2'b00;
   localparam logic [1:0] MOP_IDX_UNORD = 2'b01;
   localparam logic [1:0] MOP_STRIDED   = 2'b10;
   localparam logic [1:0] MOP_IDX_ORD   = 2'b11;

   typedef enum logic [1:0] {
      CLS_ARITH  = 2'd0,
      CLS_LOAD   = 2'd1,
      CLS_STORE  = 2'd2,
      CLS_CONFIG = 2'd3
   } req_class_e;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EMIT_CFG = 2'd1,
      S_EMIT_OP  = 2'd2
   } enc_state_e;

endpackage

// File: rtl/v_instr_pack.sv
// Combinational packing of latched request fields into one 32-bit RVV word;
// emit_cfg selects the vsetvli form, otherwise the class picks the op format.
module v_instr_pack
   import v_pkg::*;
(
   input  logic        emit_cfg,
   input  logic [1:0]  req_class,
   input  logic [5:0]  funct6,
   input  logic [2:0]  funct3,
   input  logic        vm,
   input  logic [4:0]  vd,
   input  logic [4:0]  f1,
   input  logic [4:0]  f2,
   input  logic [1:0]  mop,
   input  logic [2:0]  width,
   input  logic [10:0] zimm,
   input  logic [4:0]  avl,
   output logic [31:0] word
);

   always_comb begin
      word = '0;
      if (emit_cfg) begin
         word = {1'b0, zimm, avl, OP_SET, 5'b00000, OPC_RTYPE};
      end else begin
         case (req_class)
            CLS_ARITH: word = {funct6, vm, f2, f1, funct3, vd, OPC_RTYPE};
            CLS_LOAD:  word = {3'b000, 1'b0, mop, vm, f2, f1, width, vd, OPC_LTYPE};
            CLS_STORE: word = {3'b000, 1'b0, mop, vm, f2, f1, width, vd, OPC_STYPE};
            default:   word = '0;
         endcase
      end
   end

endmodule

// File: rtl/v_instr_encoder.sv
// Turns vector requests into RVV words, inserting a vsetvli when the vtype changes.
// One word per cycle when instr_ready is high; req_ready drops while a word is stalled.
module v_instr_encoder
   import v_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_class,
   input  logic [5:0]  req_funct6,
   input  logic [2:0]  req_funct3,
   input  logic        req_vm,
   input  logic [4:0]  req_vd,
   input  logic [4:0]  req_f1,
   input  logic [4:0]  req_f2,
   input  logic [1:0]  req_mop,
   input  logic [2:0]  req_width,
   input  logic [10:0] req_zimm,
   input  logic [4:0]  req_avl,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        err,
   output logic [10:0] cur_vtype,
   output logic        cfg_known
);

   enc_state_e  state_q, state_d;
   logic [1:0]  cls_q;
   logic [5:0]  funct6_q;
   logic [2:0]  funct3_q;
   logic        vm_q;
   logic [4:0]  vd_q, f1_q, f2_q, avl_q;
   logic [1:0]  mop_q;
   logic [2:0]  width_q;
   logic [10:0] zimm_q;
   logic        err_d, cfg_upd;
   logic        accept, handshake, illegal, need_cfg;
   enc_state_e  accept_target;
   logic [31:0] packed_word;

   assign instr_valid = (state_q != S_IDLE);
   assign req_ready   = (state_q == S_IDLE) || ((state_q == S_EMIT_OP) && instr_ready);
   assign accept      = req_valid && req_ready;
   assign handshake   = instr_valid && instr_ready;

   // funct3=111 is the OPCFG category, never a legal arithmetic operand form
   assign illegal  = (req_class == CLS_ARITH) && (req_funct3 == OP_SET);
   assign need_cfg = !cfg_known || (req_zimm != cur_vtype);

   always_comb begin
      accept_target = S_IDLE;
      if (req_class == CLS_CONFIG)
         accept_target = S_EMIT_CFG;
      else if (!illegal)
         accept_target = need_cfg ? S_EMIT_CFG : S_EMIT_OP;
   end

   always_comb begin
      state_d = state_q;
      err_d   = accept && illegal;
      cfg_upd = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept)
               state_d = accept_target;
         end
         S_EMIT_CFG: begin
            if (handshake) begin
               cfg_upd = 1'b1;
               state_d = (cls_q == CLS_CONFIG) ? S_IDLE : S_EMIT_OP;
            end
         end
         S_EMIT_OP: begin
            if (handshake)
               state_d = accept ? accept_target : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         err       <= 1'b0;
         cur_vtype <= '0;
         cfg_known <= 1'b0;
         cls_q     <= '0;
         funct6_q  <= '0;
         funct3_q  <= '0;
         vm_q      <= 1'b0;
         vd_q      <= '0;
         f1_q      <= '0;
         f2_q      <= '0;
         mop_q     <= '0;
         width_q   <= '0;
         zimm_q    <= '0;
         avl_q     <= '0;
      end else begin
         state_q <= state_d;
         err     <= err_d;
         if (cfg_upd) begin
            cur_vtype <= zimm_q;
            cfg_known <= 1'b1;
         end
         if (accept) begin
            cls_q    <= req_class;
            funct6_q <= req_funct6;
            funct3_q <= req_funct3;
            vm_q     <= req_vm;
            vd_q     <= req_vd;
            f1_q     <= req_f1;
            f2_q     <= req_f2;
            mop_q    <= req_mop;
            width_q  <= req_width;
            zimm_q   <= req_zimm;
            avl_q    <= req_avl;
         end
      end
   end

   v_instr_pack u_pack (
      .emit_cfg  (state_q == S_EMIT_CFG),
      .req_class (cls_q),
      .funct6    (funct6_q),
      .funct3    (funct3_q),
      .vm        (vm_q),
      .vd        (vd_q),
      .f1        (f1_q),
      .f2        (f2_q),
      .mop       (mop_q),
      .width     (width_q),
      .zimm      (zimm_q),
      .avl       (avl_q),
      .word      (packed_word)
   );

   assign instr = instr_valid ? packed_word : 32'h0;

endmodule

// File: tb/tb_v_instr_encoder.sv
// Directed bench for v_instr_encoder: vector table plus stall, back-to-back and reset sequences.
module tb_v_instr_encoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_class = '0;
   logic [5:0]  req_funct6 = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_vm = 1'b0;
   logic [4:0]  req_vd = '0, req_f1 = '0, req_f2 = '0, req_avl = '0;
   logic [1:0]  req_mop = '0;
   logic [2:0]  req_width = '0;
   logic [10:0] req_zimm = '0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic        err;
   logic [10:0] cur_vtype;
   logic        cfg_known;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   v_instr_encoder dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_class(req_class),
      .req_funct6(req_funct6), .req_funct3(req_funct3), .req_vm(req_vm),
      .req_vd(req_vd), .req_f1(req_f1), .req_f2(req_f2), .req_mop(req_mop),
      .req_width(req_width), .req_zimm(req_zimm), .req_avl(req_avl),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .err(err), .cur_vtype(cur_vtype), .cfg_known(cfg_known)
   );

   typedef struct {
      logic [1:0]  cls;
      logic [5:0]  f6;
      logic [2:0]  f3;
      logic        vm;
      logic [4:0]  vd, f1, f2;
      logic [1:0]  mop;
      logic [2:0]  width;
      logic [10:0] zimm;
      logic [4:0]  avl;
      logic        has_cfg;
      logic [31:0] cfg_w;
      logic        has_op;
      logic [31:0] op_w;
      logic        exp_err;
      logic [10:0] exp_vtype;
   } vec_t;

   function automatic vec_t mk(
      input logic [1:0] cls, input logic [5:0] f6, input logic [2:0] f3, input logic vm,
      input logic [4:0] vd, input logic [4:0] f1, input logic [4:0] f2, input logic [1:0] mop,
      input logic [2:0] width, input logic [10:0] zimm, input logic [4:0] avl,
      input logic has_cfg, input logic [31:0] cfg_w, input logic has_op, input logic [31:0] op_w,
      input logic exp_err, input logic [10:0] exp_vtype);
      vec_t v;
      v.cls = cls; v.f6 = f6; v.f3 = f3; v.vm = vm; v.vd = vd; v.f1 = f1; v.f2 = f2;
      v.mop = mop; v.width = width; v.zimm = zimm; v.avl = avl;
      v.has_cfg = has_cfg; v.cfg_w = cfg_w; v.has_op = has_op; v.op_w = op_w;
      v.exp_err = exp_err; v.exp_vtype = exp_vtype;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      req_class = v.cls; req_funct6 = v.f6; req_funct3 = v.f3; req_vm = v.vm;
      req_vd = v.vd; req_f1 = v.f1; req_f2 = v.f2; req_mop = v.mop;
      req_width = v.width; req_zimm = v.zimm; req_avl = v.avl;
   endtask

   task automatic expect_word(input string name, input logic [31:0] exp);
      int n = 0;
      while (!instr_valid && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!instr_valid) begin
         errors++;
         $display("FAIL %s: instr_valid never rose, expected word %h", name, exp);
      end else begin
         checks--;
         chk(name, instr, exp);
         @(posedge clk); #1;
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic seen;
      int   n = 0;
      drive(v);
      req_valid = 1'b1;
      do begin
         seen = req_ready;
         @(posedge clk); #1;
         n++;
      end while (!seen && n < 20);
      req_valid = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s accept: req_ready stayed 0, expected 1", tag);
      end
      chk({tag, " err"}, {31'b0, err}, {31'b0, v.exp_err});
      if (v.exp_err) begin
         chk({tag, " no_valid"}, {31'b0, instr_valid}, 32'd0);
         @(posedge clk); #1;
         chk({tag, " err_pulse"}, {31'b0, err}, 32'd0);
      end
      if (v.has_cfg) expect_word({tag, " vsetvli"}, v.cfg_w);
      if (v.has_op)  expect_word({tag, " op"}, v.op_w);
      chk({tag, " idle"}, {31'b0, instr_valid}, 32'd0);
      chk({tag, " vtype"}, {21'b0, cur_vtype}, {21'b0, v.exp_vtype});
      chk({tag, " known"}, {31'b0, cfg_known}, 32'd1);
   endtask

   vec_t vecs[8];
   vec_t vb;

   initial begin
      vecs[0] = mk(2'd0, 6'h00, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 2'd0, 3'd0, 11'h010, 5'd5,
                   1'b1, 32'h0102F057, 1'b1, 32'h022081D7, 1'b0, 11'h010);
      vecs[1] = mk(2'd1, 6'h00, 3'd0, 1'b1, 5'd4, 5'd10, 5'd0, 2'd0, 3'd6, 11'h010, 5'd5,
                   1'b0, 32'h0, 1'b1, 32'h02056207, 1'b0, 11'h010);
      vecs[2] = mk(2'd2, 6'h00, 3'd7, 1'b1, 5'd4, 5'd10, 5'd0, 2'd0, 3'd6, 11'h010, 5'd5,
                   1'b0, 32'h0, 1'b1, 32'h02056227, 1'b0, 11'h010);
      vecs[3] = mk(2'd0, 6'h02, 3'd4, 1'b0, 5'd8, 5'd9, 5'd12, 2'd0, 3'd0, 11'h0D1, 5'd7,
                   1'b1, 32'h0D13F057, 1'b1, 32'h08C4C457, 1'b0, 11'h0D1);
      vecs[4] = mk(2'd3, 6'h00, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 3'd0, 11'h0D1, 5'd3,
                   1'b1, 32'h0D11F057, 1'b0, 32'h0, 1'b0, 11'h0D1);
      vecs[5] = mk(2'd0, 6'h00, 3'd7, 1'b1, 5'd1, 5'd1, 5'd1, 2'd0, 3'd0, 11'h123, 5'd1,
                   1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 11'h0D1);
      vecs[6] = mk(2'd1, 6'h00, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 2'd2, 3'd5, 11'h0D1, 5'd0,
                   1'b0, 32'h0, 1'b1, 32'h08315087, 1'b0, 11'h0D1);
      vecs[7] = mk(2'd0, 6'h25, 3'd2, 1'b1, 5'd31, 5'd31, 5'd31, 2'd0, 3'd0, 11'h000, 5'd0,
                   1'b1, 32'h00007057, 1'b1, 32'h97FFAFD7, 1'b0, 11'h000);
      vb      = mk(2'd0, 6'h00, 3'd0, 1'b1, 5'd5, 5'd6, 5'd7, 2'd0, 3'd0, 11'h010, 5'd5,
                   1'b1, 32'h0102F057, 1'b1, 32'h027302D7, 1'b0, 11'h010);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset instr_valid", {31'b0, instr_valid}, 32'd0);
      chk("reset instr", instr, 32'd0);
      chk("reset err", {31'b0, err}, 32'd0);
      chk("reset cur_vtype", {21'b0, cur_vtype}, 32'd0);
      chk("reset cfg_known", {31'b0, cfg_known}, 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // stall in EMIT_CFG: word and req_ready must hold
      instr_ready = 1'b0;
      drive(vecs[0]);
      req_valid = 1'b1;
      chk("stall accept ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall%0d instr", i), instr, 32'h0102F057);
         chk($sformatf("stall%0d valid", i), {31'b0, instr_valid}, 32'd1);
         chk($sformatf("stall%0d req_ready", i), {31'b0, req_ready}, 32'd0);
         @(posedge clk); #1;
      end
      instr_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall op word", instr, 32'h022081D7);
      chk("stall vtype", {21'b0, cur_vtype}, 32'h010);

      // back-to-back: accept during the EMIT_OP handshake, no vsetvli needed
      drive(vb);
      req_valid = 1'b1;
      chk("b2b req_ready", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b valid", {31'b0, instr_valid}, 32'd1);
      chk("b2b word", instr, 32'h027302D7);
      instr_ready = 1'b0;
      @(posedge clk); #1;
      chk("op hold", instr, 32'h027302D7);

      // asynchronous reset mid EMIT_OP
      rst = 1'b1;
      #1;
      chk("midrst valid", {31'b0, instr_valid}, 32'd0);
      chk("midrst instr", instr, 32'd0);
      chk("midrst known", {31'b0, cfg_known}, 32'd0);
      chk("midrst vtype", {21'b0, cur_vtype}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      instr_ready = 1'b1;
      chk("postrst req_ready", {31'b0, req_ready}, 32'd1);
      run_vec(vb, "postrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/v_instr_encoder.md
V_INSTR_ENCODER -- requirements
Module: v_instr_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1 is the single clock, and all state updates on its rising edge.
REQ-002 The reset port SHALL be: rst  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL have these request-side ports:
 - req_valid  in  1  request present.
 - req_ready  out  1  request accepted when req_valid and req_ready are both high.
 - req_class  in  2  request kind: ARITH=0, LOAD=1, STORE=2, CONFIG=3.
 - req_funct6  in  6  arithmetic funct6; ignored for LOAD/STORE/CONFIG.
 - req_funct3  in  3  arithmetic operand category (OPI_VV, OPI_VI, OPI_VX, OPM_VV, OPM_VX); ignored otherwise.
 - req_vm  in  1  mask bit, placed in instr[25].
 - req_vd  in  5  destination register; for STORE this is vs3.
 - req_f1  in  5  vs1, rs1 or simm5 for ARITH; base rs1 for LOAD/STORE.
 - req_f2  in  5  vs2 for ARITH; lumop/sumop, rs2 or vs2 for LOAD/STORE.
 - req_mop  in  2  addressing mode for LOAD/STORE.
 - req_width  in  3  element width field for LOAD/STORE.
 - req_zimm  in  11  required vtype for this request.
 - req_avl  in  5  scalar register holding the AVL, used as rs1 of any emitted vsetvli.
REQ-004 The block SHALL have these issue-side and status ports:
 - instr  out  32  encoded RVV instruction.
 - instr_valid  out  1  instr is valid.
 - instr_ready  in  1  consumer accepts instr.
 - err  out  1  one-cycle pulse when an illegal request is dropped.
 - cur_vtype  out  11  last vtype issued.
 - cfg_known  out  1  cur_vtype is valid.

Function
REQ-005 The FSM SHALL have three states: IDLE, EMIT_CFG and EMIT_OP; instr_valid SHALL be high exactly in EMIT_CFG and EMIT_OP.
REQ-006 req_ready SHALL be high when the state is IDLE, or when the state is EMIT_OP and instr_ready is high; accepting in EMIT_OP gives back-to-back issue.
REQ-007 On accept, all request fields SHALL be latched; instr SHALL depend only on these latched fields and state, never on live request inputs.
REQ-008 On accept of ARITH, LOAD or STORE, the next state SHALL be EMIT_CFG if cfg_known=0 or req_zimm != cur_vtype; otherwise it SHALL be EMIT_OP.
REQ-009 On accept of CONFIG, the next state SHALL be EMIT_CFG, then IDLE after the handshake; no operation instruction follows.
REQ-010 In EMIT_CFG, instr SHALL be a vsetvli: {1'b0, zimm, avl, 3'b111, 5'b00000, 7'b1010111}.
REQ-011 When the EMIT_CFG handshake completes, cur_vtype SHALL take the latched zimm and cfg_known SHALL go to 1.
REQ-012 In EMIT_OP, ARITH SHALL encode as {funct6, vm, f2, f1, funct3, vd, 7'b1010111}.
REQ-013 In EMIT_OP, LOAD SHALL encode as {3'b000, 1'b0, mop, vm, f2, f1, width, vd, 7'b0000111}.
REQ-014 In EMIT_OP, STORE SHALL encode as for LOAD but with opcode 7'b0100111.
REQ-015 The EMIT_OP handshake SHALL go to IDLE, unless a new request is accepted in the same cycle; that request then follows REQ-008 using the cur_vtype already updated.
REQ-016 instr and instr_valid SHALL hold stable while instr_valid=1 and instr_ready=0 (no retraction).
REQ-017 An accepted ARITH request with funct3=3'b111 SHALL be dropped: no instruction issued, err pulses high in the next cycle, and the state returns to or stays in IDLE.
REQ-018 LOAD/STORE SHALL not check req_funct3, and all mop values SHALL be legal.

Reset
REQ-019 Asserting rst at any time, including mid-issue, SHALL force state=IDLE, instr_valid=0, instr=0, err=0, cur_vtype=0 and cfg_known=0; the pending request is discarded.
REQ-020 req_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-021 v_pkg SHALL hold the existing OPC_LTYPE, OPC_STYPE, OPC_RTYPE, OP_SET, OPI_*/OPM_* and MOP_* constants, plus a new req_class enum and the encoder state enum.
REQ-022 Field packing SHALL be a purely combinational sub-module, v_instr_pack (latched fields plus emit-cfg select in, 32-bit word out); the FSM and registers SHALL stay in the top module.

Verification
REQ-023 After reset, ARITH vadd.vv (funct6=0, funct3=0, vm=1, vd=3, f1=1, f2=2, zimm=0x010, avl=5) with instr_ready=1 -> 0x0102F057, then 0x022081D7, then cur_vtype=0x010.
REQ-024 A second ARITH with the same zimm=0x010, accepted during the EMIT_OP handshake -> no vsetvli, back-to-back words on consecutive cycles.
REQ-025 LOAD vle32 (vm=1, vd=4, f1=10, f2=0, mop=0, width=6, zimm=0x010, cfg_known=1) -> single word 0x02056207.
REQ-026 instr_ready held low for 5 cycles during EMIT_CFG -> instr held at 0x0102F057 and req_ready=0 throughout.
REQ-027 ARITH with funct3=7 -> err high for one cycle, no instr_valid.
REQ-028 rst asserted while in EMIT_OP -> instr_valid=0 immediately and cfg_known=0; the next ARITH emits a vsetvli first.
